fetch_unit: RTL and testbench

//  Two-stage instruction fetch (F1 -> F2 -> D) that consumes the pipeline's stall/flush/redirect controls.
//  F1 issues the PC to a synchronous 1-cycle-latency IMEM. F2 receives the instruction word.
//  The IF/ID register presents Instr_D, PC_D and PC_Plus4_D to decode.
//  F2 contains a hold buffer, so no instruction is lost or duplicated across stalls.

---
 rtl/fetch_unit.sv | 196 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Two-stage instruction fetch front end: F1 -> F2 -> IF/ID (decode).
//
//   F1     : holds PC_F1 and drives it to a synchronous IMEM with a read
//            latency of one cycle (imem_addr = PC_F1).
//   F2     : holds PC_F2/Valid_F2. The instruction word that belongs to PC_F2
//            is imem_rdata in the cycle after the address was sampled. If F2
//            stalls, the word is captured in a hold buffer. Once captured,
//            F2 no longer depends on what IMEM returns for the re-read address.
//   IF/ID  : presents Instr_D, PC_D, PC_Plus4_D and Valid_D to decode.
//
// Control priorities:
//   PC_F1 : redirect (PC_Src_E != 0) > Stall_F1 > PC_F1 + 4
//   F2    : Flush_F2 > Stall_F2 > load from F1
//   IF/ID : Flush_D  > Stall_D  > load from F2
//
// There is no valid/ready handshake here. The stall and flush inputs are
// level-sensitive commands from the hazard unit. They apply on the next
// rising clock edge.
//
// Parameters:
//   XLEN      - datapath / PC width
//   RESET_PC  - PC_F1 value after reset
//   NOP_INSTR - bubble instruction written into IF/ID (addi x0,x0,0)
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-high reset
//   Stall_F1/F2/D      - hold the PC / F2 stage / IF/ID register
//   Flush_F2, Flush_D  - invalidate F2 / load a bubble into IF/ID
//   PC_Src_E           - 00 sequential, 01/11 PC_Target_E, 10 ALU_Result_E
//   PC_Target_E        - branch / jal target from execute
//   ALU_Result_E       - jalr target from execute (bit 0 is forced to zero)
//   imem_addr          - IMEM read address (= PC_F1)
//   imem_rdata         - IMEM read data, one cycle after imem_addr is sampled
//   Instr_D, PC_D      - instruction and its PC, presented to decode
//   PC_Plus4_D         - PC_D + 4
//   Valid_D            - 1 for a real instruction, 0 for a bubble
//
// Optional build macro FETCH_PERF_CNT_EN:
//   When it is defined, the module adds the outputs perf_stall_cnt and
//   perf_redirect_cnt. These are free-running 32-bit counters:
//     - perf_stall_cnt counts the cycles in which PC_F1 is held by a stall.
//     - perf_redirect_cnt counts the redirect cycles.
//   When the macro is undefined, the ports and the counters do not exist.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall_F1,
    input  logic            Stall_F2,
    input  logic            Stall_D,
    input  logic            Flush_F2,
    input  logic            Flush_D,
    input  logic [1:0]      PC_Src_E,
    input  logic [XLEN-1:0] PC_Target_E,
    input  logic [XLEN-1:0] ALU_Result_E,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Instr_D,
    output logic [XLEN-1:0] PC_D,
    output logic [XLEN-1:0] PC_Plus4_D,
    output logic            Valid_D
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_redirect_cnt
`endif
);

    // PC increment. The additions wrap modulo 2^XLEN on purpose.
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // -----------------------------------------------------------------------
    // F1: program counter and redirect target selection
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] pc_f1;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    assign redirect = (PC_Src_E != 2'b00);

    always_comb begin
        redirect_pc = PC_Target_E;
        case (PC_Src_E)
            // jalr: clear bit 0 of the computed target.
            2'b10:   redirect_pc = ALU_Result_E & ~XLEN'(1);
            default: redirect_pc = PC_Target_E;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f1 <= RESET_PC;
        end else if (redirect) begin
            pc_f1 <= redirect_pc;
        end else if (!Stall_F1) begin
            pc_f1 <= pc_f1 + PC_STEP;
        end
    end

    assign imem_addr = pc_f1;

    // -----------------------------------------------------------------------
    // F2: PC / valid register
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] pc_f2;
    logic            valid_f2;

    // A flush only drops the valid bit. PC_F2 keeps its old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f2    <= '0;
            valid_f2 <= 1'b0;
        end else if (Flush_F2) begin
            valid_f2 <= 1'b0;
        end else if (!Stall_F2) begin
            pc_f2    <= pc_f1;
            valid_f2 <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // F2: hold buffer
    //
    // In the first stalled cycle, imem_rdata still carries the word for
    // PC_F2. On later stalled cycles IMEM re-reads the held PC_F1, and its
    // output no longer belongs to F2. So the word is captured once, and the
    // buffer is then used until the stall ends or F2 is flushed.
    // -----------------------------------------------------------------------
    logic [31:0] hold_q;
    logic        hold_vld;
    logic [31:0] instr_f2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q   <= '0;
            hold_vld <= 1'b0;
        end else if (Flush_F2 || !Stall_F2) begin
            hold_vld <= 1'b0;
        end else if (!hold_vld) begin
            hold_q   <= imem_rdata;
            hold_vld <= 1'b1;
        end
    end

    assign instr_f2 = hold_vld ? hold_q : imem_rdata;

    // -----------------------------------------------------------------------
    // IF/ID register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Instr_D    <= NOP_INSTR;
            PC_D       <= '0;
            PC_Plus4_D <= PC_STEP;
            Valid_D    <= 1'b0;
        end else if (Flush_D) begin
            // The bubble keeps the last PC pair, so only the word and the
            // valid bit change.
            Instr_D    <= NOP_INSTR;
            Valid_D    <= 1'b0;
        end else if (!Stall_D) begin
            Instr_D    <= valid_f2 ? instr_f2 : NOP_INSTR;
            PC_D       <= pc_f2;
            PC_Plus4_D <= pc_f2 + PC_STEP;
            Valid_D    <= valid_f2;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Performance counters. A redirect overrides Stall_F1, so a redirect
    // cycle is counted only as a redirect and not as a stall.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (Stall_F1 && !redirect) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. It includes a synchronous IMEM model whose
// read data is address + 1. That model gives IMEM[i] = i*4 + 1 for aligned
// addresses.
//
// Each cycle the bench pushes one hand-computed expected output vector into
// exp_q:
//   {imem_addr, Instr_D, PC_D, PC_Plus4_D, Valid_D}
// A monitor process pops one vector after every rising edge and compares it
// with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int W = 129;

    // Clock / reset
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DUT inputs
    logic        Stall_F1 = 1'b0, Stall_F2 = 1'b0, Stall_D = 1'b0;
    logic        Flush_F2 = 1'b0, Flush_D = 1'b0;
    logic [1:0]  PC_Src_E = 2'b00;
    logic [31:0] PC_Target_E = '0, ALU_Result_E = '0;
    logic [31:0] imem_rdata = '0;

    // DUT outputs
    logic [31:0] imem_addr, Instr_D, PC_D, PC_Plus4_D;
    logic        Valid_D;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_redirect_cnt;
`endif

    // When corrupt is set, the IMEM model returns garbage.
    logic corrupt = 1'b0;

    fetch_unit #(
        .XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk(clk), .reset(reset),
        .Stall_F1(Stall_F1), .Stall_F2(Stall_F2), .Stall_D(Stall_D),
        .Flush_F2(Flush_F2), .Flush_D(Flush_D),
        .PC_Src_E(PC_Src_E), .PC_Target_E(PC_Target_E), .ALU_Result_E(ALU_Result_E),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .Instr_D(Instr_D), .PC_D(PC_D), .PC_Plus4_D(PC_Plus4_D), .Valid_D(Valid_D)
`ifdef FETCH_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    // Synchronous IMEM with one cycle of latency.
    always @(posedge clk) begin
        imem_rdata <= corrupt ? ((imem_addr + 32'd1) ^ 32'hDEAD_BEEF) : (imem_addr + 32'd1);
    end

    // Scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if ({imem_addr, Instr_D, PC_D, PC_Plus4_D, Valid_D} !== e) begin
                n_fail++;
                $display("FAIL %s: got addr=%h instr=%h pc=%h pc4=%h v=%b, expected addr=%h instr=%h pc=%h pc4=%h v=%b",
                         nm, imem_addr, Instr_D, PC_D, PC_Plus4_D, Valid_D,
                         e[128:97], e[96:65], e[64:33], e[32:1], e[0]);
            end
        end
    end

    // Driver tasks
    task automatic set_ctl(input logic s1, input logic s2, input logic sd,
                           input logic f2, input logic fd, input logic [1:0] src,
                           input logic [31:0] tgt, input logic [31:0] alu);
        Stall_F1 = s1; Stall_F2 = s2; Stall_D = sd;
        Flush_F2 = f2; Flush_D = fd;
        PC_Src_E = src; PC_Target_E = tgt; ALU_Result_E = alu;
    endtask

    // Push the outputs expected after the next rising edge, then advance to
    // the following falling edge, where inputs are changed.
    task automatic cyc(input string nm, input logic [31:0] a, input logic [31:0] i,
                       input logic [31:0] p, input logic [31:0] p4, input logic v);
        exp_q.push_back({a, i, p, p4, v});
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        // Reset held over an edge
        cyc("reset_hold", 32'h0, NOP, 32'h0, 32'h4, 1'b0);
        reset = 1'b0;
        #1 chk("release_addr", imem_addr, 32'h0);

        // 1: sequential fetch
        cyc("seq_e1", 32'h4, NOP,   32'h0, 32'h4, 1'b0);
        cyc("seq_e2", 32'h8, 32'h1, 32'h0, 32'h4, 1'b1);
        cyc("seq_e3", 32'hC, 32'h5, 32'h4, 32'h8, 1'b1);

        // 2: full stall for 3 cycles while IMEM returns garbage
        set_ctl(1, 1, 1, 0, 0, 2'b00, 0, 0);
        corrupt = 1'b1;
        cyc("stall_1", 32'hC, 32'h5, 32'h4, 32'h8, 1'b1);
        cyc("stall_2", 32'hC, 32'h5, 32'h4, 32'h8, 1'b1);
        cyc("stall_3", 32'hC, 32'h5, 32'h4, 32'h8, 1'b1);
        set_ctl(0, 0, 0, 0, 0, 2'b00, 0, 0);
        corrupt = 1'b0;
        cyc("unstall_1", 32'h10, 32'h9, 32'h8, 32'hC,  1'b1);
        cyc("unstall_2", 32'h14, 32'hD, 32'hC, 32'h10, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
`endif

        // 3: branch redirect to 0x100
        set_ctl(0, 0, 0, 1, 1, 2'b01, 32'h100, 0);
        cyc("br_redirect", 32'h100, NOP, 32'hC, 32'h10, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_redirect_cnt", perf_redirect_cnt, 32'd1);
`endif
        set_ctl(0, 0, 0, 0, 0, 2'b00, 0, 0);
        cyc("br_bubble2", 32'h104, NOP,     32'h10,  32'h14,  1'b0);
        cyc("br_target",  32'h108, 32'h101, 32'h100, 32'h104, 1'b1);
        cyc("br_next",    32'h10C, 32'h105, 32'h104, 32'h108, 1'b1);

        // 4: jalr with odd target, then PC_Src_E=11
        set_ctl(0, 0, 0, 1, 1, 2'b10, 0, 32'h203);
        cyc("jalr_redirect", 32'h202, NOP, 32'h104, 32'h108, 1'b0);
        set_ctl(0, 0, 0, 1, 1, 2'b11, 32'h40, 0);
        cyc("src11_redirect", 32'h40, NOP, 32'h104, 32'h108, 1'b0);
        set_ctl(0, 0, 0, 0, 0, 2'b00, 0, 0);
        cyc("src11_bubble2", 32'h44, NOP,    32'h108, 32'h10C, 1'b0);
        cyc("src11_target",  32'h48, 32'h41, 32'h40,  32'h44,  1'b1);

        // 5: stall with hold buffer loaded, then stall + redirect together
        set_ctl(1, 1, 1, 0, 0, 2'b00, 0, 0);
        cyc("pre_stall", 32'h48, 32'h41, 32'h40, 32'h44, 1'b1);
        set_ctl(1, 1, 1, 1, 1, 2'b01, 32'h80, 0);
        cyc("stall_redirect", 32'h80, NOP, 32'h40, 32'h44, 1'b0);
        set_ctl(0, 0, 0, 0, 0, 2'b00, 0, 0);
        cyc("sr_bubble2", 32'h84, NOP,    32'h44, 32'h48, 1'b0);
        cyc("sr_target",  32'h88, 32'h81, 32'h80, 32'h84, 1'b1);

        // 6: reset pulse in the middle of a stall, with the hold buffer loaded
        set_ctl(1, 1, 1, 0, 0, 2'b00, 0, 0);
        cyc("stall_before_rst", 32'h88, 32'h81, 32'h80, 32'h84, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_addr",  imem_addr,  32'h0);
        chk("async_rst_instr", Instr_D,    NOP);
        chk("async_rst_pc",    PC_D,       32'h0);
        chk("async_rst_pc4",   PC_Plus4_D, 32'h4);
        chk("async_rst_valid", {31'b0, Valid_D}, 32'h0);
        cyc("rst2_hold", 32'h0, NOP, 32'h0, 32'h4, 1'b0);
        reset = 1'b0;
        set_ctl(0, 0, 0, 0, 0, 2'b00, 0, 0);
        #1 chk("release2_addr", imem_addr, 32'h0);
        cyc("rst2_e1", 32'h4, NOP,   32'h0, 32'h4, 1'b0);
        cyc("rst2_e2", 32'h8, 32'h1, 32'h0, 32'h4, 1'b1);

        // 7: PC wrap at the top of the address space
        set_ctl(0, 0, 0, 1, 1, 2'b01, 32'hFFFF_FFFC, 0);
        cyc("wrap_redirect", 32'hFFFF_FFFC, NOP, 32'h0, 32'h4, 1'b0);
        set_ctl(0, 0, 0, 0, 0, 2'b00, 0, 0);
        cyc("wrap_addr0", 32'h0, NOP,           32'h4,          32'h8, 1'b0);
        cyc("wrap_instr", 32'h4, 32'hFFFF_FFFD, 32'hFFFF_FFFC,  32'h0, 1'b1);

        // Drain the scoreboard
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
